// File: rtl/fp_addsub_pipe_if.sv
// Valid/ready handshake bundle for fp_addsub_pipe: operand side and result side.
interface fp_addsub_pipe_if #(
   parameter int EXP_W = 4,
   parameter int MAN_W = 3
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_res;
   logic [2:0]   out_flags;

   modport master (
      output in_valid, in_a, in_b, in_op, out_ready,
      input  in_ready, out_valid, out_res, out_flags
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, out_ready,
      output in_ready, out_valid, out_res, out_flags
   );
endinterface

// File: rtl/fp_addsub_pipe.sv
// Three-stage minifloat adder/subtractor with valid/ready flow control and status flags.
// Define FP_ADDSUB_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp_addsub_pipe #(
   parameter int EXP_W = 4,
   parameter int MAN_W = 3
) (
   input logic          clk,
   input logic          rst_n,
   fp_addsub_pipe_if.slave io
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int GW = MAN_W + 4;
   localparam int XW = EXP_W + $clog2(GW) + 2;

   localparam logic [EXP_W-1:0]    EMAX   = '1;
   localparam logic signed [XW-1:0] ZERO_X = '0;
   localparam logic signed [XW-1:0] ONE_X  = XW'(1);
   localparam logic signed [XW-1:0] EMAX_X = XW'((1 << EXP_W) - 1);

   // Right shift that ORs every bit pushed out into the sticky position.
   function automatic logic [GW-1:0] shr_sticky(input logic [GW-1:0] v,
                                                input logic [EXP_W-1:0] d);
      logic [GW-1:0] r;
      logic          st;
      r  = v;
      st = 1'b0;
      for (int i = 0; i < (1 << EXP_W) - 1; i++) begin
         if (i < int'(d)) begin
            st = st | r[0];
            r  = r >> 1;
         end
      end
      return {r[GW-1:1], r[0] | st};
   endfunction

   function automatic logic [XW-1:0] lzc(input logic [GW-1:0] v);
      logic [XW-1:0] n;
      n = XW'(GW);
      for (int i = 0; i < GW; i++)
         if (v[i]) n = XW'(GW - 1 - i);
      return n;
   endfunction

   // Returns {carry out of the stored mantissa, stored mantissa}.
   function automatic logic [MAN_W:0] round_man(input logic [GW-1:0] m);
`ifdef FP_ADDSUB_RNE_EN
      logic up;
      up = m[2] & (m[1] | m[0] | m[3]);
      return {1'b0, m[GW-2:3]} + {{MAN_W{1'b0}}, up};
`else
      return {1'b0, m[GW-2:3]};
`endif
   endfunction

   // Returns {invalid, overflow, underflow, packed result}.
   function automatic logic [W+2:0] pack_sat(input logic sign,
                                             input logic signed [XW-1:0] e,
                                             input logic [MAN_W:0] r,
                                             input logic zero);
      logic signed [XW-1:0] e_r;
      if (zero) return '0;
      if (e <= ZERO_X) return {3'b001, sign, {(W-1){1'b0}}};
      e_r = r[MAN_W] ? e + ONE_X : e;
      if (e_r >= EMAX_X) return {3'b010, sign, EMAX, {MAN_W{1'b0}}};
      return {3'b000, sign, e_r[EXP_W-1:0], r[MAN_W-1:0]};
   endfunction

   logic vld_p1, vld_p2, vld_p3;
   logic stall;

   assign stall       = vld_p3 && !io.out_ready;
   assign io.in_ready = !stall;
   assign io.out_valid = vld_p3;

   // ---- stage 1: unpack, classify, swap, align ----
   logic             sa, sb;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] ma, mb;
   logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big;
   logic [EXP_W-1:0] exp_l_s1, exp_s_s1;
   logic [MAN_W-1:0] man_l_s1, man_s_s1;
   logic             spec_s1, spec_inv_s1;
   logic [W-1:0]     spec_res_s1;

   assign sa = io.in_a[W-1];
   assign ea = io.in_a[W-2:MAN_W];
   assign ma = io.in_a[MAN_W-1:0];
   assign sb = io.in_b[W-1] ^ io.in_op;
   assign eb = io.in_b[W-2:MAN_W];
   assign mb = io.in_b[MAN_W-1:0];

   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_inf  = (ea == EMAX) && (ma == '0);
   assign b_inf  = (eb == EMAX) && (mb == '0);
   assign a_nan  = (ea == EMAX) && (ma != '0);
   assign b_nan  = (eb == EMAX) && (mb != '0);
   assign a_big  = {ea, ma} >= {eb, mb};

   assign exp_l_s1 = a_big ? ea : eb;
   assign exp_s_s1 = a_big ? eb : ea;
   assign man_l_s1 = a_big ? ma : mb;
   assign man_s_s1 = a_big ? mb : ma;

   always_comb begin
      spec_s1     = 1'b1;
      spec_inv_s1 = 1'b0;
      spec_res_s1 = '0;
      if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
         spec_inv_s1 = 1'b1;
         spec_res_s1 = {1'b0, EMAX, {MAN_W{1'b1}}};
      end else if (a_inf) begin
         spec_res_s1 = {sa, EMAX, {MAN_W{1'b0}}};
      end else if (b_inf) begin
         spec_res_s1 = {sb, EMAX, {MAN_W{1'b0}}};
      end else if (a_zero && b_zero) begin
         spec_res_s1 = {sa & sb, {(W-1){1'b0}}};
      end else if (b_zero) begin
         spec_res_s1 = io.in_a;
      end else if (a_zero) begin
         spec_res_s1 = {sb, eb, mb};
      end else begin
         spec_s1 = 1'b0;
      end
   end

   logic             sign_p1, sub_p1, spec_p1, spec_inv_p1;
   logic [W-1:0]     spec_res_p1;
   logic [EXP_W-1:0] exp_p1;
   logic [GW-1:0]    man_l_p1, man_s_p1;

   always_ff @(posedge clk) begin
      if (!stall && io.in_valid) begin
         sign_p1     <= a_big ? sa : sb;
         sub_p1      <= sa ^ sb;
         spec_p1     <= spec_s1;
         spec_inv_p1 <= spec_inv_s1;
         spec_res_p1 <= spec_res_s1;
         exp_p1      <= exp_l_s1;
         man_l_p1    <= {1'b1, man_l_s1, 3'b000};
         man_s_p1    <= shr_sticky({1'b1, man_s_s1, 3'b000}, exp_l_s1 - exp_s_s1);
      end
   end

   // ---- stage 2: magnitude add/subtract ----
   logic [GW:0]      sum_s2;
   logic [GW:0]      sum_p2;
   logic             sign_p2, spec_p2, spec_inv_p2;
   logic [W-1:0]     spec_res_p2;
   logic [EXP_W-1:0] exp_p2;

   assign sum_s2 = sub_p1 ? ({1'b0, man_l_p1} - {1'b0, man_s_p1})
                          : ({1'b0, man_l_p1} + {1'b0, man_s_p1});

   always_ff @(posedge clk) begin
      if (!stall && vld_p1) begin
         sum_p2      <= sum_s2;
         sign_p2     <= sign_p1;
         spec_p2     <= spec_p1;
         spec_inv_p2 <= spec_inv_p1;
         spec_res_p2 <= spec_res_p1;
         exp_p2      <= exp_p1;
      end
   end

   // ---- stage 3: normalise, round, pack ----
   logic signed [XW-1:0] exp_ext_p2, exp_s3;
   logic [XW-1:0]        lz_s3;
   logic [GW-1:0]        norm_s3;
   logic [MAN_W:0]       rnd_s3;
   logic                 zero_s3;
   logic [W-1:0]         res_p3;
   logic [2:0]           flags_p3;

   assign exp_ext_p2 = $signed({{(XW-EXP_W){1'b0}}, exp_p2});

   always_comb begin
      lz_s3 = lzc(sum_p2[GW-1:0]);
      if (sum_p2[GW]) begin
         norm_s3 = {sum_p2[GW:2], sum_p2[1] | sum_p2[0]};
         exp_s3  = exp_ext_p2 + ONE_X;
      end else begin
         norm_s3 = sum_p2[GW-1:0] << lz_s3;
         exp_s3  = exp_ext_p2 - $signed(lz_s3);
      end
   end

   assign zero_s3 = (norm_s3 == '0);
   assign rnd_s3  = round_man(norm_s3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         vld_p3 <= 1'b0;
      end else if (!stall) begin
         vld_p1 <= io.in_valid;
         vld_p2 <= vld_p1;
         vld_p3 <= vld_p2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_p3   <= '0;
         flags_p3 <= '0;
      end else if (!stall && vld_p2) begin
         if (spec_p2) begin
            res_p3   <= spec_res_p2;
            flags_p3 <= {spec_inv_p2, 2'b00};
         end else begin
            {flags_p3, res_p3} <= pack_sat(sign_p2, exp_s3, rnd_s3, zero_s3);
         end
      end
   end

   assign io.out_res   = res_p3;
   assign io.out_flags = flags_p3;
endmodule
